coprosit_result_arbiter: RTL and testbench
==========================================

// Module: coprosit_result_arbiter
// PURPOSE
//  Merges N_CH independent result streams (PRAU, load path, future units) onto the single
//  X-interface result channel of the Coprosit unit. Each source gets a one-entry buffer;
//  a round-robin arbiter with grant lock drives the output. Compile-time in-order mode
//  commits results strictly in offload-ID order.
// PARAMETERS
//  N_CH         2   number of result sources (>=1)
//  ORDER_DEPTH  4   entries in the issue-order ID FIFO (power of 2, in-order mode only)
//  result_t     coprosit_pkg::x_result_t   result payload type (id, data, rd, we, exc, ...)
// PORTS
//  clk_i           in   1               clock
//  rst_ni          in   1               asynchronous reset, active low
//  ch_valid_i      in   N_CH            source c has a result
//  ch_ready_o      out  N_CH            buffer c accepts this cycle
//  ch_result_i     in   N_CH x result_t source payloads
//  result_valid_o  out  1               X-if result valid
//  result_ready_i  in   1               X-if result ready
//  result_o        out  result_t        X-if result payload
//  issue_push_i    in   1               offloaded instr accepted; record its ID (in-order mode)
//  issue_id_i      in   X_ID_WIDTH      ID of that instruction
//  order_full_o    out  1               order FIFO full; issuer must stall offload
// BEHAVIOUR
//  - Reset: all buffers invalid, rr pointer=0, lock=0, order FIFO empty; result_valid_o=0,
//    ch_ready_o='1 (all buffers empty), order_full_o=0, result_o='0.
//  - Buffer c: captures ch_result_i[c] on ch_valid_i[c]&ch_ready_o[c]. ch_ready_o[c] =
//    !buf_v[c] | (granted c & result_ready_i) (bypass refill on same-cycle drain). No
//    combinational path from ch_valid_i to result_valid_o: min latency 1 cycle (accept at
//    edge t -> result_valid_o high in cycle after t). Full throughput 1 result/cycle.
//  - Eligibility: out-of-order mode eligible[c]=buf_v[c]; in-order mode eligible[c]=
//    buf_v[c] & buf[c].id==order head & order FIFO not empty.
//  - Arbitration: round robin starting at rr pointer; lowest index >= rr wins, wrapping.
//    result_valid_o = |eligible; result_o = buf[grant] (all-zero when not valid).
//  - Lock: if result_valid_o & !result_ready_i, grant and result_o frozen next cycle
//    (X-if: valid never retracts, payload stable). Lock clears on handshake.
//  - On handshake: buf_v[grant] cleared (unless refilled same cycle), rr <= grant+1 mod N_CH,
//    in-order mode pops order FIFO.
//  - Order FIFO: push on issue_push_i & !order_full_o; push while full is ignored (issuer
//    contract violation, assertion fires). Simultaneous push+pop when full: both take effect,
//    stays full. Pointers wrap mod ORDER_DEPTH, extra wrap bit distinguishes full/empty.
//  - Two buffers holding same ID: lower index wins in in-order mode (assertion flags it).
//  - N_CH=1: arbiter degenerates to pass-through buffer; rr pointer constant 0.
//  - Reset mid-transfer discards buffered results and order FIFO contents without output.
// CONFIGURATION
//  COPROSIT_RESULT_INORDER_EN defined: order FIFO instantiated; results issued in
//  issue_push_i order regardless of completion order; order_full_o live.
//  Not defined: order FIFO absent, issue_push_i/issue_id_i ignored, order_full_o tied 0,
//  pure round robin (out-of-order completion, core reorders via id).
// STRUCTURE
//  coprosit_pkg: x_result_t (existing), new localparams RESULT_N_CH=2, RESULT_ORDER_DEPTH=4,
//  enum result_src_e {SrcPrau, SrcMem} used as channel indices.
//  Sub-module coprosit_id_fifo: ORDER_DEPTH x X_ID_WIDTH FIFO (push/pop/head/full/empty),
//  async active-low reset. Arbiter and buffers stay in this module.
// TESTING
//  1 Reset: assert rst_ni=0 mid-stream -> result_valid_o=0, ch_ready_o=2'b11, order_full_o=0.
//  2 RR: both channels valid every cycle, ready=1, ids 1,2 -> outputs alternate ch0,ch1,ch0;
//    one result per cycle, no loss.
//  3 Backpressure: ch1 result id=5 buffered, result_ready_i=0 for 3 cycles while ch0 valid
//    -> result_o holds id=5 stable, ch0 not granted until id=5 handshakes.
//  4 In-order (macro on): push ids 3,7; ch1 delivers 7 first, ch0 delivers 3 two cycles later
//    -> output id 3 then 7; 7 held in buffer, ch_ready_o[1]=0 until drained.
//  5 Order full: push 4 ids with no pop -> order_full_o=1; push+pop same cycle -> stays 1,
//    head advances; 5th push while full ignored.
//  6 Macro off: issue_push_i toggling has no effect; completion order 7,3 -> output 7,3.

Source files
------------

// File: rtl/coprosit_pkg.sv
`default_nettype none
// ============================================================================
// coprosit_pkg
// Shared X-interface result type, result-arbiter sizing and source indices.
// Rev 1.0
// ============================================================================
package coprosit_pkg;

  localparam int X_ID_WIDTH = 4;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [31:0]           data;
    logic [4:0]            rd;
    logic                  we;
    logic                  exc;
    logic [5:0]            exccode;
  } x_result_t;

  localparam int RESULT_N_CH        = 2;
  localparam int RESULT_ORDER_DEPTH = 4;

  typedef enum logic [0:0] {
    SrcPrau = 1'b0,
    SrcMem  = 1'b1
  } result_src_e;

  // Index width that stays legal (>=1 bit) for single-entry structures.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/coprosit_id_fifo.sv
`default_nettype none
// ============================================================================
// coprosit_id_fifo
// Offload-ID order FIFO; push while full is accepted only alongside a pop.
// Rev 1.0
// ============================================================================
module coprosit_id_fifo
  import coprosit_pkg::*;
#(
  parameter int DEPTH = RESULT_ORDER_DEPTH,
  parameter int WIDTH = X_ID_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = idx_width(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB separates full (wrap bits differ) from empty.
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) begin
      mem_d[wptr_q[AW-1:0]] = push_data_i;
      wptr_d                = wptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/coprosit_result_arbiter.sv
`default_nettype none
// ============================================================================
// coprosit_result_arbiter
// Merges N_CH buffered result streams onto the X-if result channel with a
// locking round-robin arbiter. COPROSIT_RESULT_INORDER_EN enables ID-ordered commit.
// Rev 1.0
// ============================================================================
module coprosit_result_arbiter
  import coprosit_pkg::*;
#(
  parameter int  N_CH        = RESULT_N_CH,
  parameter int  ORDER_DEPTH = RESULT_ORDER_DEPTH,
  parameter type result_t    = x_result_t
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [N_CH-1:0]       ch_valid_i,
  output logic [N_CH-1:0]       ch_ready_o,
  input  result_t               ch_result_i [N_CH],
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output result_t               result_o,
  input  logic                  issue_push_i,
  input  logic [X_ID_WIDTH-1:0] issue_id_i,
  output logic                  order_full_o
);

  localparam int GW = idx_width(N_CH);

  logic [N_CH-1:0] buf_v_q, buf_v_d;
  result_t         buf_q [N_CH];
  result_t         buf_d [N_CH];
  logic [GW-1:0]   rr_q, rr_d;
  logic [GW-1:0]   lock_grant_q, lock_grant_d;
  logic            lock_q, lock_d;
  logic [N_CH-1:0] eligible;
  logic [GW-1:0]   grant;
  logic            handshake;

`ifdef COPROSIT_RESULT_INORDER_EN
  logic [X_ID_WIDTH-1:0] order_head;
  logic                  order_empty;

  coprosit_id_fifo #(
    .DEPTH (ORDER_DEPTH),
    .WIDTH (X_ID_WIDTH)
  ) u_order_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (issue_push_i),
    .push_data_i (issue_id_i),
    .pop_i       (handshake),
    .head_o      (order_head),
    .full_o      (order_full_o),
    .empty_o     (order_empty)
  );

  always_comb begin
    eligible = '0;
    for (int c = 0; c < N_CH; c++) begin
      eligible[c] = buf_v_q[c] & (buf_q[c].id == order_head) & ~order_empty;
    end
  end

  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(issue_push_i && order_full_o && !handshake))
        else $warning("order FIFO push while full dropped id %0d", issue_id_i);
      assert ($onehot0(eligible))
        else $warning("several result buffers hold the order-head id");
    end
  end
`else
  logic unused_issue;

  assign eligible     = buf_v_q;
  assign order_full_o = 1'b0;
  assign unused_issue = ^{issue_push_i, issue_id_i, ORDER_DEPTH[0]};
`endif

  // Grant selection; a locked grant is held until its handshake.
  always_comb begin
    logic [GW:0] sum;
    logic        found;
    grant = rr_q;
    found = 1'b0;
    sum   = '0;
    if (lock_q) begin
      grant = lock_grant_q;
    end else begin
`ifdef COPROSIT_RESULT_INORDER_EN
      for (int c = N_CH - 1; c >= 0; c--) begin
        if (eligible[c]) begin
          grant = GW'(c);
        end
      end
`else
      for (int i = 0; i < N_CH; i++) begin
        sum = {1'b0, rr_q} + (GW+1)'(i);
        if (sum >= (GW+1)'(N_CH)) begin
          sum = sum - (GW+1)'(N_CH);
        end
        if (!found && eligible[sum[GW-1:0]]) begin
          grant = sum[GW-1:0];
          found = 1'b1;
        end
      end
`endif
    end
  end

  assign result_valid_o = |eligible;
  assign result_o       = result_valid_o ? buf_q[grant] : '0;
  assign handshake      = result_valid_o & result_ready_i;

  // A buffer draining this cycle may refill in the same cycle.
  always_comb begin
    buf_v_d    = buf_v_q;
    buf_d      = buf_q;
    ch_ready_o = '0;
    for (int c = 0; c < N_CH; c++) begin
      ch_ready_o[c] = ~buf_v_q[c] | (handshake & (grant == GW'(c)));
      if (handshake && (grant == GW'(c))) begin
        buf_v_d[c] = 1'b0;
      end
      if (ch_valid_i[c] && ch_ready_o[c]) begin
        buf_v_d[c] = 1'b1;
        buf_d[c]   = ch_result_i[c];
      end
    end
  end

  always_comb begin
    rr_d         = rr_q;
    lock_d       = result_valid_o & ~result_ready_i;
    lock_grant_d = grant;
    if (handshake) begin
      rr_d = (int'(grant) == N_CH - 1) ? '0 : grant + GW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_v_q      <= '0;
      rr_q         <= '0;
      lock_q       <= 1'b0;
      lock_grant_q <= '0;
      for (int c = 0; c < N_CH; c++) begin
        buf_q[c] <= '0;
      end
    end else begin
      buf_v_q      <= buf_v_d;
      rr_q         <= rr_d;
      lock_q       <= lock_d;
      lock_grant_q <= lock_grant_d;
      buf_q        <= buf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_coprosit_result_arbiter.sv
`default_nettype none
// ============================================================================
// tb_coprosit_result_arbiter
// Vector table plus directed sequences; outputs checked against a scoreboard queue.
// Rev 1.0
// ============================================================================
module tb_coprosit_result_arbiter;
  import coprosit_pkg::*;

  localparam int N_CH = RESULT_N_CH;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [N_CH-1:0]       ch_valid = '0;
  logic [N_CH-1:0]       ch_ready;
  x_result_t             ch_result [N_CH];
  logic                  result_valid;
  logic                  result_ready = 1'b1;
  x_result_t             result;
  logic                  issue_push = 1'b0;
  logic [X_ID_WIDTH-1:0] issue_id = '0;
  logic                  order_full;

  x_result_t sb_q[$];
  x_result_t sb_exp;
  int        n_checks = 0;
  int        n_fail   = 0;
  int        n_out    = 0;

  always #5 clk = ~clk;

  coprosit_result_arbiter #(
    .N_CH        (N_CH),
    .ORDER_DEPTH (RESULT_ORDER_DEPTH),
    .result_t    (x_result_t)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .ch_valid_i     (ch_valid),
    .ch_ready_o     (ch_ready),
    .ch_result_i    (ch_result),
    .result_valid_o (result_valid),
    .result_ready_i (result_ready),
    .result_o       (result),
    .issue_push_i   (issue_push),
    .issue_id_i     (issue_id),
    .order_full_o   (order_full)
  );

  function automatic x_result_t mk(input logic [X_ID_WIDTH-1:0] id);
    x_result_t r;
    r         = '0;
    r.id      = id;
    r.data    = 32'hC0DE_0000 | 32'(id);
    r.rd      = 5'(id);
    r.we      = 1'b1;
    r.exccode = 6'(id);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_id(input logic [X_ID_WIDTH-1:0] id);
    issue_push = 1'b1;
    issue_id   = id;
    tick();
    issue_push = 1'b0;
  endtask

  // Scoreboard: every output handshake pops and compares one expected result.
  always @(negedge clk) begin
    if (rst_n && result_valid && result_ready) begin
      n_out++;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: actual id=%0d data=%h, required no output", result.id, result.data);
      end else begin
        sb_exp = sb_q.pop_front();
        if (result !== sb_exp) begin
          n_fail++;
          $display("FAIL sb_result: actual id=%0d data=%h, required id=%0d data=%h",
                   result.id, result.data, sb_exp.id, sb_exp.data);
        end
      end
    end
  end

  typedef struct {
    logic                  v0;
    logic [X_ID_WIDTH-1:0] id0;
    logic                  v1;
    logic [X_ID_WIDTH-1:0] id1;
    int                    n_exp;
    logic [X_ID_WIDTH-1:0] e0;
    logic [X_ID_WIDTH-1:0] e1;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int k0, k1, start, vcnt;
    logic a0, a1;

    // Expected orders follow the round-robin pointer carried across vectors.
    vecs[0] = '{1'b1, 4'd1,  1'b1, 4'd2,  2, 4'd1,  4'd2};
    vecs[1] = '{1'b0, 4'd0,  1'b1, 4'd3,  1, 4'd3,  4'd0};
    vecs[2] = '{1'b1, 4'd4,  1'b0, 4'd0,  1, 4'd4,  4'd0};
    vecs[3] = '{1'b1, 4'd5,  1'b1, 4'd6,  2, 4'd6,  4'd5};
    vecs[4] = '{1'b1, 4'd7,  1'b1, 4'd8,  2, 4'd8,  4'd7};
    vecs[5] = '{1'b0, 4'd0,  1'b1, 4'd9,  1, 4'd9,  4'd0};
    vecs[6] = '{1'b1, 4'd10, 1'b1, 4'd11, 2, 4'd10, 4'd11};

    for (int c = 0; c < N_CH; c++) ch_result[c] = '0;

    #1;
    chk("reset_valid", 64'(result_valid), 64'd0);
    chk("reset_ready", 64'(ch_ready), 64'd3);
    chk("reset_full",  64'(order_full), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Table-driven single-shot transactions.
    for (int i = 0; i < 7; i++) begin
`ifdef COPROSIT_RESULT_INORDER_EN
      push_id(vecs[i].e0);
      if (vecs[i].n_exp == 2) push_id(vecs[i].e1);
`endif
      sb_q.push_back(mk(vecs[i].e0));
      if (vecs[i].n_exp == 2) sb_q.push_back(mk(vecs[i].e1));
      chk("vec_ready_idle", 64'(ch_ready), 64'd3);
      ch_valid     = {vecs[i].v1, vecs[i].v0};
      ch_result[0] = mk(vecs[i].id0);
      ch_result[1] = mk(vecs[i].id1);
      result_ready = 1'b1;
      tick();
      ch_valid = '0;
      repeat (4) tick();
      chk("vec_drained", 64'(sb_q.size()), 64'd0);
    end

`ifndef COPROSIT_RESULT_INORDER_EN
    // Both channels streaming: strict alternation at one result per cycle.
    for (int k = 1; k <= 8; k++) sb_q.push_back(mk(4'(k)));
    k0 = 0; k1 = 0; vcnt = 0; start = n_out;
    for (int cyc = 0; cyc < 10; cyc++) begin
      ch_valid[SrcPrau] = (k0 < 4);
      ch_valid[SrcMem]  = (k1 < 4);
      ch_result[SrcPrau] = mk(4'(2 * k0 + 1));
      ch_result[SrcMem]  = mk(4'(2 * k1 + 2));
      #1;
      if (result_valid) vcnt++;
      a0 = ch_valid[SrcPrau] & ch_ready[SrcPrau];
      a1 = ch_valid[SrcMem]  & ch_ready[SrcMem];
      tick();
      if (a0) k0++;
      if (a1) k1++;
    end
    ch_valid = '0;
    chk("stream_outputs", 64'(n_out - start), 64'd8);
    chk("stream_valid_cycles", 64'(vcnt), 64'd8);
    chk("stream_drained", 64'(sb_q.size()), 64'd0);
`endif

    // Backpressure: a stalled grant keeps its payload even when ch0 becomes eligible.
`ifdef COPROSIT_RESULT_INORDER_EN
    push_id(4'd5);
    push_id(4'd1);
`endif
    sb_q.push_back(mk(4'd5));
    sb_q.push_back(mk(4'd1));
    result_ready = 1'b0;
    ch_valid = 2'b10;
    ch_result[SrcMem] = mk(4'd5);
    tick();
    ch_valid = 2'b01;
    ch_result[SrcPrau] = mk(4'd1);
    tick();
    ch_valid = '0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", 64'(result_valid), 64'd1);
      chk("bp_hold_id", 64'(result.id), 64'd5);
      chk("bp_ready", 64'(ch_ready), 64'd0);
      tick();
    end
    result_ready = 1'b1;
    repeat (3) tick();
    chk("bp_drained", 64'(sb_q.size()), 64'd0);

`ifdef COPROSIT_RESULT_INORDER_EN
    // Completion order 7,3 against issue order 3,7.
    push_id(4'd3);
    push_id(4'd7);
    sb_q.push_back(mk(4'd3));
    sb_q.push_back(mk(4'd7));
    ch_valid = 2'b10;
    ch_result[SrcMem] = mk(4'd7);
    tick();
    ch_valid = '0;
    for (int i = 0; i < 2; i++) begin
      chk("io_wait_valid", 64'(result_valid), 64'd0);
      chk("io_wait_ready1", 64'(ch_ready[SrcMem]), 64'd0);
      tick();
    end
    ch_valid = 2'b01;
    ch_result[SrcPrau] = mk(4'd3);
    tick();
    ch_valid = '0;
    chk("io_first_id", 64'(result.id), 64'd3);
    repeat (3) tick();
    chk("io_drained", 64'(sb_q.size()), 64'd0);

    // Order FIFO full, push+pop while full, push while full dropped.
    for (int i = 1; i <= 4; i++) push_id(4'(i));
    chk("of_full4", 64'(order_full), 64'd1);
    sb_q.push_back(mk(4'd1));
    ch_valid = 2'b01;
    ch_result[SrcPrau] = mk(4'd1);
    tick();
    ch_valid = '0;
    chk("of_pop_valid", 64'(result_valid), 64'd1);
    push_id(4'd5);
    chk("of_push_pop_full", 64'(order_full), 64'd1);
    push_id(4'd6);
    chk("of_hold_full", 64'(order_full), 64'd1);
    for (int i = 2; i <= 5; i++) sb_q.push_back(mk(4'(i)));
    for (int i = 2; i <= 5; i++) begin
      ch_valid = 2'b01;
      ch_result[SrcPrau] = mk(4'(i));
      tick();
    end
    ch_valid = '0;
    repeat (3) tick();
    chk("of_drained", 64'(sb_q.size()), 64'd0);
    chk("of_not_full", 64'(order_full), 64'd0);
    ch_valid = 2'b01;
    ch_result[SrcPrau] = mk(4'd6);
    tick();
    ch_valid = '0;
    repeat (2) tick();
    chk("of_dropped_id", 64'(result_valid), 64'd0);
`else
    // Issue port ignored; completion order 7,3 is output order.
    sb_q.push_back(mk(4'd7));
    sb_q.push_back(mk(4'd3));
    for (int cyc = 0; cyc < 6; cyc++) begin
      issue_push = cyc[0];
      issue_id   = 4'(cyc + 3);
      ch_valid   = '0;
      if (cyc == 0) begin
        ch_valid[SrcMem]  = 1'b1;
        ch_result[SrcMem] = mk(4'd7);
      end
      if (cyc == 2) begin
        ch_valid[SrcPrau]  = 1'b1;
        ch_result[SrcPrau] = mk(4'd3);
      end
      #1;
      chk("ooo_full_tied", 64'(order_full), 64'd0);
      tick();
    end
    issue_push = 1'b0;
    ch_valid   = '0;
    chk("ooo_drained", 64'(sb_q.size()), 64'd0);
`endif

    // Reset mid-stream discards buffered results.
    result_ready = 1'b0;
    ch_valid = 2'b11;
    ch_result[SrcPrau] = mk(4'd12);
    ch_result[SrcMem]  = mk(4'd13);
    tick();
    ch_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(result_valid), 64'd0);
    chk("rst_mid_ready", 64'(ch_ready), 64'd3);
    chk("rst_mid_full",  64'(order_full), 64'd0);
    chk("rst_mid_result", 64'(result), 64'd0);
    tick();
    rst_n = 1'b1;
    result_ready = 1'b1;
    repeat (3) tick();
    chk("rst_discard_valid", 64'(result_valid), 64'd0);
    chk("rst_discard_ready", 64'(ch_ready), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
